// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the stage registers it drives.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_MULDIV = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_write: 1'b1,
        id_ex_flush: 1'b0, ex_mem_write: 1'b1, ex_mem_flush: 1'b0, mem_wb_flush: 1'b0
    };

    localparam pipe_ctrl_t CTRL_INIT = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_write: 1'b0,
        id_ex_flush: 1'b1, ex_mem_write: 1'b0, ex_mem_flush: 1'b1, mem_wb_flush: 1'b1
    };

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic       uses_rs1,
        input logic [4:0] rs1,
        input logic       uses_rs2,
        input logic [4:0] rs2
    );
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard inputs from the pipeline and the per-register control it receives back.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_Rs1;
    logic [4:0]       ID_Rs2;
    logic             ID_UsesRs1;
    logic             ID_UsesRs2;
    logic             EX_MemRead;
    logic [4:0]       EX_Rd;
    logic             EX_BranchTaken;
    logic             EX_IsMulDiv;
    logic             muldiv_done;
    logic             MEM_MemAccess;
    logic             dmem_ready;

    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_write;
    logic             ID_EX_flush;
    logic             EX_MEM_write;
    logic             EX_MEM_flush;
    logic             MEM_WB_flush;
    logic             muldiv_start;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             mem_timeout_err;

    modport master (
        output ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_Rd,
               EX_BranchTaken, EX_IsMulDiv, muldiv_done, MEM_MemAccess, dmem_ready,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
               EX_MEM_write, EX_MEM_flush, MEM_WB_flush, muldiv_start,
               stall_count, flush_count, mem_timeout_err
    );

    modport slave (
        input  ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_Rd,
               EX_BranchTaken, EX_IsMulDiv, muldiv_done, MEM_MemAccess, dmem_ready,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
               EX_MEM_write, EX_MEM_flush, MEM_WB_flush, muldiv_start,
               stall_count, flush_count, mem_timeout_err
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash,
// multi-cycle mul/div occupancy of EX and data-memory wait states.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_hazard_controller_if.slave  hz
);
    localparam int              WC_W        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] TIMEOUT_LIM = WC_W'(MEM_TIMEOUT);

    hz_state_t       state_q, state_d;
    pipe_ctrl_t      ctrl;
    logic            mem_wait, load_use, muldiv_start, stall_inc, flush_inc;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign mem_wait = (state_q != ST_INIT) && hz.MEM_MemAccess && !hz.dmem_ready;
    assign load_use = load_use_hit(hz.EX_MemRead, hz.EX_Rd, hz.ID_UsesRs1, hz.ID_Rs1,
                                   hz.ID_UsesRs2, hz.ID_Rs2);

    always_comb begin
        state_d      = state_q;
        ctrl         = CTRL_RUN;
        muldiv_start = 1'b0;
        flush_inc    = 1'b0;
        case (state_q)
            ST_INIT: begin
                ctrl    = CTRL_INIT;
                state_d = ST_RUN;
            end
            default: begin
                // A memory wait freezes everything upstream of MEM; pending
                // branch/load-use/mul-div decisions are re-evaluated on release.
                if (mem_wait) begin
                    ctrl.pc_write     = 1'b0;
                    ctrl.if_id_write  = 1'b0;
                    ctrl.id_ex_write  = 1'b0;
                    ctrl.ex_mem_write = 1'b0;
                    ctrl.mem_wb_flush = 1'b1;
                end else if (state_q == ST_MULDIV) begin
                    if (hz.muldiv_done) begin
                        state_d = ST_RUN;
                    end else begin
                        ctrl.pc_write     = 1'b0;
                        ctrl.if_id_write  = 1'b0;
                        ctrl.id_ex_write  = 1'b0;
                        ctrl.ex_mem_write = 1'b0;
                        ctrl.ex_mem_flush = 1'b1;
                    end
                end else if (hz.EX_IsMulDiv) begin
                    muldiv_start      = 1'b1;
                    ctrl.pc_write     = 1'b0;
                    ctrl.if_id_write  = 1'b0;
                    ctrl.id_ex_write  = 1'b0;
                    ctrl.ex_mem_write = 1'b0;
                    ctrl.ex_mem_flush = 1'b1;
                    state_d           = ST_MULDIV;
                end else if (hz.EX_BranchTaken) begin
                    ctrl.if_id_write = 1'b0;
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_write = 1'b0;
                    ctrl.id_ex_flush = 1'b1;
                    flush_inc        = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.if_id_write = 1'b0;
                    ctrl.id_ex_write = 1'b0;
                    ctrl.id_ex_flush = 1'b1;
                end
            end
        endcase
    end

    assign stall_inc = (state_q != ST_INIT) && !ctrl.pc_write;

    always_comb begin
        wait_cnt_d = '0;
        if (mem_wait)
            wait_cnt_d = (wait_cnt_q == TIMEOUT_LIM) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
        err_d = err_q || (wait_cnt_d == TIMEOUT_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_inc),
        .count (flush_cnt)
    );

    assign hz.PC_write        = ctrl.pc_write;
    assign hz.IF_ID_write     = ctrl.if_id_write;
    assign hz.IF_ID_flush     = ctrl.if_id_flush;
    assign hz.ID_EX_write     = ctrl.id_ex_write;
    assign hz.ID_EX_flush     = ctrl.id_ex_flush;
    assign hz.EX_MEM_write    = ctrl.ex_mem_write;
    assign hz.EX_MEM_flush    = ctrl.ex_mem_flush;
    assign hz.MEM_WB_flush    = ctrl.mem_wb_flush;
    assign hz.muldiv_start    = muldiv_start;
    assign hz.stall_count     = stall_cnt;
    assign hz.flush_count     = flush_cnt;
    assign hz.mem_timeout_err = err_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with a cycle-level hazard model.
module tb_pipeline_hazard_controller;
    import pipeline_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int TO    = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    // Model state: which phase the pipeline is in, plus counter values.
    bit m_init = 1'b1;
    bit m_md   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;
    int m_wcnt  = 0;
    bit m_err   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_f, start}
    function automatic logic [8:0] expect_ctrl();
        logic wt, start, busy, squash, lu, hold;
        if (m_init) return 9'b001010110;
        wt     = hz.MEM_MemAccess && !hz.dmem_ready;
        start  = !m_md && !wt && hz.EX_IsMulDiv;
        busy   = m_md && !wt && !hz.muldiv_done;
        squash = !m_md && !wt && !hz.EX_IsMulDiv && hz.EX_BranchTaken;
        lu     = !m_md && !wt && !hz.EX_IsMulDiv && !hz.EX_BranchTaken &&
                 hz.EX_MemRead && (hz.EX_Rd != 5'd0) &&
                 ((hz.ID_UsesRs1 && hz.ID_Rs1 == hz.EX_Rd) ||
                  (hz.ID_UsesRs2 && hz.ID_Rs2 == hz.EX_Rd));
        hold   = wt || start || busy;
        return {!(hold || lu), !(hold || lu || squash), squash, !(hold || lu || squash),
                squash || lu, !hold, start || busy, wt, start};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [8:0] e;
        logic       wt;
        int         nw;
        if (!rst_n) begin
            m_init  <= 1'b1;
            m_md    <= 1'b0;
            m_stall <= 0;
            m_flush <= 0;
            m_wcnt  <= 0;
            m_err   <= 1'b0;
        end else if (m_init) begin
            m_init <= 1'b0;
        end else begin
            e  = expect_ctrl();
            wt = hz.MEM_MemAccess && !hz.dmem_ready;
            if (!e[8]) m_stall <= (m_stall < SAT) ? m_stall + 1 : SAT;
            if (e[6])  m_flush <= (m_flush < SAT) ? m_flush + 1 : SAT;
            nw = wt ? ((m_wcnt < TO) ? m_wcnt + 1 : TO) : 0;
            m_wcnt <= nw;
            if (nw == TO) m_err <= 1'b1;
            if (e[0]) m_md <= 1'b1;
            else if (m_md && !wt && hz.muldiv_done) m_md <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("ctrl", {23'd0, hz.PC_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_write,
                       hz.ID_EX_flush, hz.EX_MEM_write, hz.EX_MEM_flush, hz.MEM_WB_flush,
                       hz.muldiv_start}, {23'd0, expect_ctrl()});
        check("stall_count", 32'(hz.stall_count), 32'(m_stall));
        check("flush_count", 32'(hz.flush_count), 32'(m_flush));
        check("mem_timeout_err", 32'(hz.mem_timeout_err), 32'(m_err));
    end

    task automatic idle();
        hz.ID_Rs1 = 5'd0; hz.ID_Rs2 = 5'd0; hz.ID_UsesRs1 = 1'b0; hz.ID_UsesRs2 = 1'b0;
        hz.EX_MemRead = 1'b0; hz.EX_Rd = 5'd0; hz.EX_BranchTaken = 1'b0;
        hz.EX_IsMulDiv = 1'b0; hz.muldiv_done = 1'b0;
        hz.MEM_MemAccess = 1'b0; hz.dmem_ready = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    int starts, held, wbf;

    initial begin
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset values, release, then asynchronous reset in the middle of a mul/div
        repeat (3) cyc();
        mid();
        check("init_pc_write", 32'(hz.PC_write), 32'd0);
        check("init_flushes", 32'({hz.IF_ID_flush, hz.ID_EX_flush, hz.EX_MEM_flush, hz.MEM_WB_flush}), 32'hF);
        cyc();
        rst_n = 1'b1;
        cyc();
        mid();
        check("run_writes", 32'({hz.PC_write, hz.IF_ID_write, hz.ID_EX_write, hz.EX_MEM_write}), 32'hF);
        cyc();
        hz.EX_IsMulDiv = 1'b1;
        repeat (3) cyc();
        #1 rst_n = 1'b0;
        #1;
        check("async_pc_write", 32'(hz.PC_write), 32'd0);
        check("async_flushes", 32'({hz.IF_ID_flush, hz.ID_EX_flush, hz.EX_MEM_flush, hz.MEM_WB_flush}), 32'hF);
        check("async_stall_cnt", 32'(hz.stall_count), 32'd0);
        cyc();
        idle();
        rst_n = 1'b1;
        cyc();
        mid();
        check("rerun_writes", 32'({hz.PC_write, hz.IF_ID_write, hz.ID_EX_write, hz.EX_MEM_write}), 32'hF);
        cyc();

        // Load-use: lw x5 in EX, add x6,x5,x7 in ID
        do_reset();
        hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd5;
        hz.ID_UsesRs1 = 1'b1; hz.ID_Rs1 = 5'd5; hz.ID_UsesRs2 = 1'b1; hz.ID_Rs2 = 5'd7;
        mid();
        check("lu_pc_write", 32'(hz.PC_write), 32'd0);
        check("lu_id_ex_flush", 32'(hz.ID_EX_flush), 32'd1);
        cyc();
        idle();
        mid();
        check("lu_stall_cnt", 32'(hz.stall_count), 32'd1);
        check("lu_one_cycle", 32'(hz.PC_write), 32'd1);
        cyc();
        hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd0; hz.ID_UsesRs1 = 1'b1; hz.ID_Rs1 = 5'd0;
        mid();
        check("lu_x0_no_stall", 32'(hz.PC_write), 32'd1);
        cyc();
        hz.EX_Rd = 5'd9; hz.ID_Rs1 = 5'd3; hz.ID_UsesRs2 = 1'b1; hz.ID_Rs2 = 5'd9;
        mid();
        check("lu_rs2_stall", 32'(hz.PC_write), 32'd0);
        cyc();
        hz.ID_UsesRs2 = 1'b0;
        mid();
        check("lu_rs2_unused", 32'(hz.PC_write), 32'd1);
        cyc();
        idle();
        mid();
        check("lu_stall_cnt2", 32'(hz.stall_count), 32'd2);
        cyc();

        // Taken branch overrides load-use on the squashed ID instruction
        do_reset();
        hz.EX_BranchTaken = 1'b1; hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd5;
        hz.ID_UsesRs1 = 1'b1; hz.ID_Rs1 = 5'd5;
        mid();
        check("br_pc_ifflush_idflush", 32'({hz.PC_write, hz.IF_ID_flush, hz.ID_EX_flush}), 32'h7);
        cyc();
        idle();
        mid();
        check("br_flush_cnt", 32'(hz.flush_count), 32'd1);
        check("br_stall_cnt", 32'(hz.stall_count), 32'd0);
        cyc();

        // Mul/div with done eight cycles after start
        do_reset();
        hz.EX_IsMulDiv = 1'b1;
        starts = 0; held = 0;
        for (int i = 0; i <= 8; i++) begin
            hz.muldiv_done = (i == 8);
            mid();
            starts += int'(hz.muldiv_start);
            held   += int'(hz.EX_MEM_flush);
            if (i == 8)
                check("md_release", 32'({hz.PC_write, hz.IF_ID_write, hz.ID_EX_write, hz.EX_MEM_write}), 32'hF);
            cyc();
        end
        idle();
        mid();
        check("md_start_pulses", 32'(starts), 32'd1);
        check("md_held_cycles", 32'(held), 32'd8);
        check("md_stall_cnt", 32'(hz.stall_count), 32'd8);
        cyc();

        // Memory wait holds a mul/div start until the access completes
        do_reset();
        hz.MEM_MemAccess = 1'b1; hz.dmem_ready = 1'b0; hz.EX_IsMulDiv = 1'b1;
        starts = 0; wbf = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            starts += int'(hz.muldiv_start);
            wbf    += int'(hz.MEM_WB_flush);
            cyc();
        end
        hz.dmem_ready = 1'b1;
        mid();
        check("mw_no_early_start", 32'(starts), 32'd0);
        check("mw_wb_flush_cycles", 32'(wbf), 32'd3);
        check("mw_start_on_release", 32'(hz.muldiv_start), 32'd1);
        cyc();
        hz.MEM_MemAccess = 1'b0; hz.muldiv_done = 1'b1;
        cyc();
        idle();
        cyc();

        // Wait timeout is sticky; stall counter saturates
        do_reset();
        hz.MEM_MemAccess = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mid();
            if (i == 3) check("to_not_yet", 32'(hz.mem_timeout_err), 32'd0);
            if (i == 4) check("to_set", 32'(hz.mem_timeout_err), 32'd1);
            cyc();
        end
        hz.dmem_ready = 1'b1;
        mid();
        check("to_sticky", 32'(hz.mem_timeout_err), 32'd1);
        check("to_stall_cnt", 32'(hz.stall_count), 32'd6);
        cyc();
        hz.dmem_ready = 1'b0;
        repeat (12) cyc();
        mid();
        check("to_stall_sat", 32'(hz.stall_count), 32'd15);
        check("to_still_set", 32'(hz.mem_timeout_err), 32'd1);
        cyc();
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
